axis_adder_v1_0_s00_axis: RTL and testbench
===========================================

AXIS_ADDER_V1_0_S00_AXIS -- requirements
Module: axis_adder_v1_0_s00_axis

Interface
REQ-001 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 64, the beat width W in bits.
REQ-002 SHALL have parameter PACKETS_NUM, default 13 (784 features / 64, rounded up), the buffer depth in beats; legal range 2..64.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 s_axis_tdata  in  W  upstream beat data.
REQ-007 s_axis_tvalid  in  1  upstream beat valid.
REQ-008 s_axis_tready  out  1  buffer can accept a beat.
REQ-009 s_axis_tlast  in  1  last beat of an upstream frame; accepted but not stored.
REQ-010 valid  out  PACKETS_NUM  occupancy bitmap; bit i = physical slot i holds an unread beat.
REQ-011 full  out  1  all PACKETS_NUM slots occupied.
REQ-012 m_axis_tdata  out  W  oldest stored beat, toward the inference pipeline.
REQ-013 m_axis_tvalid  out  1  m_axis_tdata is valid (buffer not empty).
REQ-014 m_axis_tready  in  1  downstream consumes the head beat.

Function
REQ-015 SHALL be a first-in-first-out buffer of PACKETS_NUM entries of W bits, with a write pointer, a read pointer and an occupancy count of 0..PACKETS_NUM.
REQ-016 SHALL drive s_axis_tready = !full while rst_n is high, and 0 while rst_n is low.
REQ-017 Push: on a clock edge with s_axis_tvalid && s_axis_tready, SHALL write s_axis_tdata to slot wr_ptr, set valid[wr_ptr], and advance wr_ptr.
REQ-018 Pop: on a clock edge with m_axis_tvalid && m_axis_tready, SHALL clear valid[rd_ptr] and advance rd_ptr.
REQ-019 Both pointers SHALL wrap from PACKETS_NUM-1 to 0; PACKETS_NUM need not be a power of two.
REQ-020 Simultaneous push and pop SHALL both take effect in the same cycle, with the count unchanged.
REQ-021 Pushing when full SHALL be impossible because s_axis_tready is 0; popping when empty SHALL be impossible because m_axis_tvalid is 0.
REQ-022 full SHALL be 1 exactly when count == PACKETS_NUM, i.e. valid is all ones; full and valid are registered state.
REQ-023 m_axis_tvalid SHALL be 1 exactly when count != 0.
REQ-024 m_axis_tdata SHALL equal the contents of slot rd_ptr when m_axis_tvalid is 1, and all zeros otherwise.
REQ-025 Latency: a beat accepted at edge k SHALL be visible on m_axis_tdata/m_axis_tvalid after edge k when the buffer was empty; there is no bypass path in the same cycle.
REQ-026 Beat order SHALL be preserved exactly.
REQ-027 No data SHALL be lost or duplicated under any tvalid/tready pattern.
REQ-028 s_axis_tlast SHALL NOT affect buffer state.

Reset
REQ-029 While rst_n is low: wr_ptr = 0, rd_ptr = 0, count = 0, valid = 0, full = 0, m_axis_tvalid = 0, m_axis_tdata = 0, s_axis_tready = 0.
REQ-030 Reset asserted mid-operation SHALL discard all stored beats immediately; storage contents need not be cleared.
REQ-031 On the first edge after rst_n rises, s_axis_tready SHALL be 1.

Structure
REQ-032 A shared package SHALL hold the default W (64), the default PACKETS_NUM (13) and a pointer-width function equal to $clog2(PACKETS_NUM).
REQ-033 SHALL be a single module with no sub-module; storage is a register array with no reset.

Verification
REQ-034 Reset, then push 13 beats 0x1..0xD with m_axis_tready=0 -> valid=13'h1FFF, full=1, s_axis_tready=0 after the 13th beat.
REQ-035 From full, m_axis_tready=1 for 13 cycles -> m_axis_tdata is 0x1..0xD in order, then m_axis_tvalid=0, m_axis_tdata=0, valid=0.
REQ-036 Continuous push and pop with both tvalid and tready at 1 for 40 beats -> count stays 1, pointers wrap past 12 to 0, output order intact.
REQ-037 With 12 entries stored, push and pop in the same cycle -> full stays 0, valid keeps 12 bits set, pointers shift by one.
REQ-038 Reset asserted with 5 entries stored -> valid=0, m_axis_tvalid=0 immediately; after release s_axis_tready=1 and the next pushed beat appears first.
REQ-039 Random tvalid/tready at 50% with s_axis_tlast every 13th beat -> scoreboard matches every beat; tlast does not change occupancy.

Source files
------------

// File: rtl/axis_adder_v1_0_s00_axis_pkg.sv
// Shared defaults for the AXI-Stream input beat buffer.
// Beat width, buffer depth and pointer sizing helper.
package axis_adder_v1_0_s00_axis_pkg;

    localparam int DEF_TDATA_W     = 64;
    localparam int DEF_PACKETS_NUM = 13;

    function automatic int ptr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/axis_adder_v1_0_s00_axis.sv
// AXI-Stream input FIFO feeding the inference pipeline.
// Depth need not be a power of two; pointers wrap explicitly.
module axis_adder_v1_0_s00_axis
    import axis_adder_v1_0_s00_axis_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = DEF_TDATA_W,
    parameter int PACKETS_NUM          = DEF_PACKETS_NUM
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [PACKETS_NUM-1:0]          valid,
    output logic                            full,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready
);

    localparam int PW = ptr_w(PACKETS_NUM);
    localparam int CW = $clog2(PACKETS_NUM + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t LAST_SLOT = ptr_t'(PACKETS_NUM - 1);
    localparam cnt_t DEPTH     = cnt_t'(PACKETS_NUM);

    logic [C_S_AXIS_TDATA_WIDTH-1:0] mem [PACKETS_NUM];

    ptr_t                   wr_ptr;
    ptr_t                   rd_ptr;
    cnt_t                   count;
    cnt_t                   count_nxt;
    logic                   full_q;
    logic [PACKETS_NUM-1:0] valid_q;
    logic [PACKETS_NUM-1:0] valid_nxt;
    logic                   push;
    logic                   pop;
    logic                   unused_tlast;

    function automatic ptr_t nxt(input ptr_t p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // tlast is framing only; the buffer does not track frames
    assign unused_tlast = s_axis_tlast;

    assign s_axis_tready = rst_n && !full_q;
    assign m_axis_tvalid = (count != '0);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign valid         = valid_q;
    assign full          = full_q;

    assign push = s_axis_tvalid && s_axis_tready;
    assign pop  = m_axis_tvalid && m_axis_tready;

    always_comb begin
        valid_nxt = valid_q;
        if (pop)
            valid_nxt[rd_ptr] = 1'b0;
        if (push)
            valid_nxt[wr_ptr] = 1'b1;
    end

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            count   <= count_nxt;
            valid_q <= valid_nxt;
            full_q  <= (count_nxt == DEPTH);
        end
    end

endmodule

// File: tb/tb_axis_adder_v1_0_s00_axis.sv
// Self-checking bench for the AXI-Stream input FIFO.
// Queue scoreboard plus a table for the fill/drain sequence.
module tb_axis_adder_v1_0_s00_axis;

    localparam int W = 64;
    localparam int N = 13;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [N-1:0] valid;
    logic         full;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;

    axis_adder_v1_0_s00_axis #(
        .C_S_AXIS_TDATA_WIDTH(W),
        .PACKETS_NUM(N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .valid(valid),
        .full(full),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    logic [W-1:0] q[$];
    int           m_rd;
    int           n_push;

    typedef struct {
        logic         tv;
        logic [W-1:0] d;
        logic         mr;
        logic [N-1:0] ev;
        logic         ef;
        logic         etr;
        logic         etv;
        logic [W-1:0] etd;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_valid();
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < q.size(); k++)
            v[(m_rd + k) % N] = 1'b1;
        return v;
    endfunction

    task automatic check_model();
        chk("s_tready", W'(s_axis_tready), W'(rst_n && q.size() != N));
        chk("m_tvalid", W'(m_axis_tvalid), W'(q.size() != 0));
        chk("m_tdata", m_axis_tdata, (q.size() != 0) ? q[0] : '0);
        chk("valid", W'(valid), W'(exp_valid()));
        chk("full", W'(full), W'(q.size() == N));
    endtask

    // Entered just after a negedge; returns on the following negedge.
    task automatic cycle(input logic tv, input logic [W-1:0] d,
                         input logic tl, input logic mr);
        logic psh;
        logic pp;
        s_axis_tvalid = tv;
        s_axis_tdata  = d;
        s_axis_tlast  = tl;
        m_axis_tready = mr;
        #1;
        check_model();
        psh = tv && (q.size() != N);
        pp  = mr && (q.size() != 0);
        @(posedge clk);
        if (pp) begin
            void'(q.pop_front());
            m_rd = (m_rd + 1) % N;
        end
        if (psh) begin
            q.push_back(d);
            n_push++;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_rd = 0;
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         tl;
        n_vec  = 0;
        n_bad  = 0;
        m_rd   = 0;
        n_push = 0;

        for (int i = 0; i < 13; i++) begin
            tbl[i].tv  = 1'b1;
            tbl[i].d   = W'(i + 1);
            tbl[i].mr  = 1'b0;
            tbl[i].ev  = N'((14'd1 << i) - 14'd1);
            tbl[i].ef  = 1'b0;
            tbl[i].etr = 1'b1;
            tbl[i].etv = (i != 0);
            tbl[i].etd = (i != 0) ? W'(1) : W'(0);
        end
        for (int j = 0; j < 13; j++) begin
            tbl[13+j].tv  = 1'b0;
            tbl[13+j].d   = '0;
            tbl[13+j].mr  = 1'b1;
            tbl[13+j].ev  = 13'h1FFF & ~N'((14'd1 << j) - 14'd1);
            tbl[13+j].ef  = (j == 0);
            tbl[13+j].etr = (j != 0);
            tbl[13+j].etv = 1'b1;
            tbl[13+j].etd = W'(j + 1);
        end

        rst_n         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        chk("rst_tready", W'(s_axis_tready), '0);
        chk("rst_tvalid", W'(m_axis_tvalid), '0);
        chk("rst_tdata", m_axis_tdata, '0);
        chk("rst_valid", W'(valid), '0);
        chk("rst_full", W'(full), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full with no drain, then drain in order.
        for (int i = 0; i < 26; i++) begin
            s_axis_tvalid = tbl[i].tv;
            s_axis_tdata  = tbl[i].d;
            m_axis_tready = tbl[i].mr;
            #1;
            chk("tbl_valid", W'(valid), W'(tbl[i].ev));
            chk("tbl_full", W'(full), W'(tbl[i].ef));
            chk("tbl_tready", W'(s_axis_tready), W'(tbl[i].etr));
            chk("tbl_tvalid", W'(m_axis_tvalid), W'(tbl[i].etv));
            chk("tbl_tdata", m_axis_tdata, tbl[i].etd);
            cycle(tbl[i].tv, tbl[i].d, 1'b0, tbl[i].mr);
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        chk("drained_valid", W'(valid), '0);
        chk("drained_tvalid", W'(m_axis_tvalid), '0);
        chk("drained_tdata", m_axis_tdata, '0);
        chk("drained_full", W'(full), '0);

        // Streaming push+pop; pointers wrap several times.
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 64'h1000 + W'(i), 1'b0, 1'b1);
        chk("stream_cnt1", W'($countones(valid)), W'(1));
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Twelve stored, then simultaneous push and pop.
        for (int i = 0; i < 12; i++)
            cycle(1'b1, 64'h2000 + W'(i), 1'b0, 1'b0);
        cycle(1'b1, 64'h2100, 1'b0, 1'b1);
        #1;
        chk("pp12_full", W'(full), '0);
        chk("pp12_cnt", W'($countones(valid)), W'(12));
        for (int i = 0; i < 12; i++)
            cycle(1'b0, '0, 1'b0, 1'b1);

        // Reset mid-operation with five entries stored.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 64'h3000 + W'(i), 1'b0, 1'b0);
        s_axis_tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", W'(valid), '0);
        chk("mid_rst_tvalid", W'(m_axis_tvalid), '0);
        chk("mid_rst_tdata", m_axis_tdata, '0);
        chk("mid_rst_tready", W'(s_axis_tready), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 64'hABC, 1'b0, 1'b0);
        chk("post_rst_first", m_axis_tdata, 64'hABC);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Random handshakes with periodic tlast.
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom, $urandom};
            tl = ((n_push % 13) == 12);
            cycle(1'($urandom_range(0, 1)), rd, tl,
                  1'($urandom_range(0, 1)));
        end
        while (q.size() != 0)
            cycle(1'b0, '0, 1'b0, 1'b1);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
